// File: rtl/baud_gen_frac.sv
`default_nettype none
// ============================================================================
// baud_gen_frac : fractional-divider baud tick generator producing oversample,
//                 mid-bit and end-of-bit ticks with a programmable divisor.
// Revision      : 1.0
// ============================================================================
module baud_gen_frac #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FRAC_W     = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             resync,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] div_active,
  output logic             os_tick,
  output logic             mid_tick,
  output logic             bit_tick
);

  localparam logic [DIV_W-1:0] DIV_DEFAULT =
    DIV_W'((64'(CLOCK_FREQ) << FRAC_W) / (64'(BAUD_RATE) * 64'(OVERSAMPLE)));
  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [DIV_W:0]   c_step     = {{DIV_W{1'b0}}, 1'b1} << FRAC_W;
  localparam logic [DIV_W-1:0] c_min_div  = {{(DIV_W-1){1'b0}}, 1'b1} << (FRAC_W + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] c_cnt_mid  = CNT_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] r_acc;
  logic [CNT_W-1:0] r_os_cnt;
  logic             r_pend_valid;
  logic [DIV_W-1:0] r_pend_div;

  logic [DIV_W:0]   w_sum;
  logic [DIV_W-1:0] w_rem;
  logic             w_hit;
  logic             w_run;
  logic             w_last;
  logic             w_mid;
  logic             w_bit;
  logic             w_apply;
  logic             w_accept;
  logic             w_bad;

  // Remainder is taken modulo 2^DIV_W: the true value is below div_active.
  assign w_sum    = {1'b0, r_acc} + c_step;
  assign w_rem    = w_sum[DIV_W-1:0] - div_active;
  assign w_hit    = (w_sum >= {1'b0, div_active});
  assign w_run    = enable && !resync;
  assign w_last   = (r_os_cnt == c_cnt_last);
  assign w_mid    = (r_os_cnt == c_cnt_mid);
  assign w_bit    = w_run && w_hit && w_last;
  assign w_apply  = r_pend_valid && (!w_run || w_bit);
  assign w_accept = cfg_valid && cfg_ready;
  assign w_bad    = (cfg_div < c_min_div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc        <= '0;
      r_os_cnt     <= '0;
      r_pend_valid <= 1'b0;
      r_pend_div   <= '0;
      div_active   <= DIV_DEFAULT;
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
      os_tick      <= 1'b0;
      mid_tick     <= 1'b0;
      bit_tick     <= 1'b0;
    end else begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      cfg_err  <= 1'b0;

      if (!w_run) begin
        r_acc    <= '0;
        r_os_cnt <= '0;
      end else if (w_hit) begin
        os_tick  <= 1'b1;
        mid_tick <= w_mid;
        bit_tick <= w_last;
        r_acc    <= w_rem;
        r_os_cnt <= w_last ? '0 : r_os_cnt + CNT_W'(1);
      end else begin
        r_acc <= w_sum[DIV_W-1:0];
      end

      // Apply restarts the phase but leaves a coincident bit_tick intact.
      if (w_apply) begin
        div_active   <= r_pend_div;
        r_acc        <= '0;
        r_os_cnt     <= '0;
        r_pend_valid <= 1'b0;
        cfg_ready    <= 1'b1;
      end else if (w_accept) begin
        if (w_bad) begin
          cfg_err <= 1'b1;
        end else begin
          r_pend_div   <= cfg_div;
          r_pend_valid <= 1'b1;
          cfg_ready    <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_baud_gen_frac.sv
`default_nettype none
// ============================================================================
// tb_baud_gen_frac : self-checking bench for baud_gen_frac against an
//                    arithmetic tick-schedule reference model.
// Revision         : 1.0
// ============================================================================
module tb_baud_gen_frac;

  localparam int OS        = 4;
  localparam int FW        = 4;
  localparam int SCALE     = 1 << FW;
  localparam int C_DEF_OS4 = (50000000 * SCALE) / (9600 * OS);
  localparam int C_DEF     = 5208;

  logic        clk = 1'b0;
  logic        reset_n, enable, resync, cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready, cfg_err, os_tick, mid_tick, bit_tick;
  logic [15:0] div_active;

  logic        rst2_n, en2, rs2, cv2;
  logic [15:0] cd2;
  logic        ready2, err2, os2, mid2, bit2;
  logic [15:0] div2;

  always #5 clk = ~clk;

  baud_gen_frac #(.OVERSAMPLE(OS), .FRAC_W(FW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .resync(resync),
    .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .div_active(div_active), .os_tick(os_tick),
    .mid_tick(mid_tick), .bit_tick(bit_tick)
  );

  baud_gen_frac dut_def (
    .clk(clk), .reset_n(rst2_n), .enable(en2), .resync(rs2),
    .cfg_valid(cv2), .cfg_div(cd2), .cfg_ready(ready2),
    .cfg_err(err2), .div_active(div2), .os_tick(os2),
    .mid_tick(mid2), .bit_tick(bit2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference: after a phase restart, tick k lands on step ceil(k*div/SCALE).
  longint m_div, m_n, m_k, m_pend_div;
  bit     m_pend;
  bit     e_os, e_mid, e_bit, e_err;

  task automatic m_reset();
    m_div = C_DEF_OS4; m_n = 0; m_k = 0; m_pend = 0; m_pend_div = 0;
    e_os = 0; e_mid = 0; e_bit = 0; e_err = 0;
  endtask

  task automatic m_step(input bit en, input bit rs, input bit cv, input logic [15:0] cd);
    bit restart;
    restart = !en || rs;
    e_os = 0; e_mid = 0; e_bit = 0; e_err = 0;
    if (!restart) begin
      m_n++;
      if ((m_n * SCALE) / m_div != ((m_n - 1) * SCALE) / m_div) begin
        m_k++;
        e_os  = 1;
        e_mid = (m_k % OS == OS / 2);
        e_bit = (m_k % OS == 0);
      end
    end
    if (m_pend && (restart || e_bit)) begin
      m_div = m_pend_div; m_pend = 0; restart = 1;
    end else if (cv && !m_pend) begin
      if (cd < 2 * SCALE) e_err = 1;
      else begin m_pend = 1; m_pend_div = cd; end
    end
    if (restart) begin m_n = 0; m_k = 0; end
  endtask

  // Called at a negedge; drives inputs, clocks once, checks at the next negedge.
  task automatic step(input bit en, input bit rs, input bit cv, input logic [15:0] cd);
    enable = en; resync = rs; cfg_valid = cv; cfg_div = cd;
    @(posedge clk);
    m_step(en, rs, cv, cd);
    @(negedge clk);
    check("os_tick", os_tick, e_os);
    check("mid_tick", mid_tick, e_mid);
    check("bit_tick", bit_tick, e_bit);
    check("cfg_err", cfg_err, e_err);
    check("cfg_ready", cfg_ready, !m_pend);
    check("div_active", div_active, m_div);
  endtask

  initial begin
    int cnt_os, cnt_bit, cnt_mid, first_os, first_bit;
    bit got;
    reset_n = 0; enable = 0; resync = 0; cfg_valid = 0; cfg_div = '0;
    rst2_n = 0; en2 = 0; rs2 = 0; cv2 = 0; cd2 = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_os", os_tick, 0);
    check("rst_mid", mid_tick, 0);
    check("rst_bit", bit_tick, 0);
    check("rst_err", cfg_err, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_div", div_active, C_DEF_OS4);
    reset_n = 1;

    // Divisor 5.0: period 5, bit every 20
    step(0, 0, 1, 16'h0050); step(0, 0, 0, 16'h0);
    cnt_os = 0; cnt_bit = 0; cnt_mid = 0; first_bit = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1, 0, 0, 16'h0);
      if (os_tick) cnt_os++;
      if (mid_tick) cnt_mid++;
      if (bit_tick) begin cnt_bit++; if (first_bit == 0) first_bit = i; end
    end
    check("t1_os_count", cnt_os, 8);
    check("t1_mid_count", cnt_mid, 2);
    check("t1_bit_count", cnt_bit, 2);
    check("t1_first_bit", first_bit, 20);

    // Divisor 2.5: 10 ticks in 25 clocks
    step(0, 0, 1, 16'h0028); step(0, 0, 0, 16'h0);
    cnt_os = 0;
    for (int i = 1; i <= 25; i++) begin
      step(1, 0, 0, 16'h0);
      if (os_tick) cnt_os++;
    end
    check("t2_os_count", cnt_os, 10);

    // Mid-bit reprogram waits for bit boundary; second offer ignored
    step(0, 0, 1, 16'h0050); step(0, 0, 0, 16'h0);
    repeat (7) step(1, 0, 0, 16'h0);
    step(1, 0, 1, 16'h0060);
    check("t3_ready_low", cfg_ready, 0);
    step(1, 0, 1, 16'h0040);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step(1, 0, 0, 16'h0);
      if (bit_tick) got = 1;
    end
    check("t3_bit_seen", got, 1);
    check("t3_div_applied", div_active, 16'h0060);
    check("t3_ready_back", cfg_ready, 1);
    cnt_os = 0;
    for (int i = 1; i <= 24; i++) begin
      step(1, 0, 0, 16'h0);
      if (os_tick) cnt_os++;
    end
    check("t3_os_count", cnt_os, 4);

    // Illegal divisor
    step(1, 0, 1, 16'h001F);
    check("t4_err", cfg_err, 1);
    check("t4_div_kept", div_active, 16'h0060);
    check("t4_ready", cfg_ready, 1);
    step(1, 0, 0, 16'h0);
    check("t4_err_pulse", cfg_err, 0);

    // resync on the cycle a tick is due
    step(0, 0, 1, 16'h0050); step(0, 0, 0, 16'h0);
    repeat (4) step(1, 0, 0, 16'h0);
    step(1, 1, 0, 16'h0);
    check("t5_tick_suppressed", os_tick, 0);
    first_os = 0; first_bit = 0;
    for (int i = 1; i <= 30 && first_bit == 0; i++) begin
      step(1, 0, 0, 16'h0);
      if (os_tick && first_os == 0) first_os = i;
      if (bit_tick) first_bit = i;
    end
    check("t5_first_os", first_os, 5);
    check("t5_first_bit", first_bit, 20);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit en, rs, cv;
      logic [15:0] cd;
      en = ($urandom_range(0, 99) >= 3);
      rs = ($urandom_range(0, 99) < 3);
      cv = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 3) == 0) cd = 16'($urandom_range(0, 31));
      else cd = 16'($urandom_range(32, 160));
      step(en, rs, cv, cd);
    end

    // Asynchronous reset mid-operation with a pending divisor
    step(0, 0, 1, 16'h0030); step(0, 0, 0, 16'h0);
    step(1, 0, 1, 16'h0070);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1, 0, 0, 16'h0);
      if (os_tick) got = 1;
    end
    check("rst2_tick_seen", got, 1);
    #2 reset_n = 0;
    #1;
    check("arst_os", os_tick, 0);
    check("arst_div", div_active, C_DEF_OS4);
    check("arst_ready", cfg_ready, 1);
    @(negedge clk);
    m_reset();
    reset_n = 1;
    repeat (5) step(0, 0, 0, 16'h0);

    // Default parameters: 9600 Bd at 50 MHz
    reset_n = 0;
    check("def_div", div2, C_DEF);
    rst2_n = 1; en2 = 1;
    cnt_os = 0; cnt_bit = 0; cnt_mid = 0;
    for (int i = 0; i < 2 * C_DEF; i++) begin
      @(posedge clk); @(negedge clk);
      if (os2) cnt_os++;
      if (mid2) cnt_mid++;
      if (bit2) cnt_bit++;
    end
    check("def_os_count", cnt_os, 32);
    check("def_mid_count", cnt_mid, 2);
    check("def_bit_count", cnt_bit, 2);

    en2 = 0; cv2 = 1; cd2 = 16'h0100;
    @(negedge clk);
    cv2 = 0;
    @(negedge clk);
    check("def_div_prog", div2, 16'h0100);
    en2 = 1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (os2) got = 1;
    end
    check("def_tick_seen", got, 1);
    #2 rst2_n = 0;
    #1;
    check("def_arst_os", os2, 0);
    check("def_arst_div", div2, C_DEF);
    check("def_arst_ready", ready2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
